// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed seven-segment scanner with per-frame snapshot and
// field blinking for the hh.mm.ss display; anodes and cathodes are active-low.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hrstens,
  input  logic [3:0] hrsones,
  input  logic [3:0] mintens,
  input  logic [3:0] minones,
  input  logic [3:0] sectens,
  input  logic [3:0] secones,
  input  logic [1:0] mode,
  input  logic       blank_lz,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  logic [RC_W-1:0] rc;
  logic [2:0]      idx;
  logic [FC_W-1:0] fcnt;
  logic            phase;

  logic [3:0] hrstens_p0, hrsones_p0, mintens_p0, minones_p0, sectens_p0, secones_p0;
  logic [1:0] mode_p0;
  logic       blank_lz_p0;

  logic       last_digit, frame_wrap;
  logic [3:0] digit;
  logic       in_field, lit;
  logic [7:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  assign last_digit = (rc == RC_LAST);
  assign frame_wrap = last_digit && (idx == 3'd5);

  // Stage p0: scan counters and frame snapshot; stage p1: registered pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc          <= '0;
      idx         <= '0;
      fcnt        <= '0;
      phase       <= 1'b1;
      hrstens_p0  <= '0;
      hrsones_p0  <= '0;
      mintens_p0  <= '0;
      minones_p0  <= '0;
      sectens_p0  <= '0;
      secones_p0  <= '0;
      mode_p0     <= '0;
      blank_lz_p0 <= 1'b0;
      an          <= 8'hFF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
    end else begin
      rc <= last_digit ? '0 : rc + 1'b1;
      if (last_digit)
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      if (frame_wrap) begin
        hrstens_p0  <= hrstens;
        hrsones_p0  <= hrsones;
        mintens_p0  <= mintens;
        minones_p0  <= minones;
        sectens_p0  <= sectens;
        secones_p0  <= secones;
        mode_p0     <= mode;
        blank_lz_p0 <= blank_lz;
        if (fcnt == FC_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

  always_comb begin
    digit    = secones_p0;
    in_field = 1'b0;
    an_nxt   = 8'hFF;
    seg_nxt  = 7'h7F;
    dp_nxt   = 1'b1;
    case (idx)
      3'd0:    digit = secones_p0;
      3'd1:    digit = sectens_p0;
      3'd2:    digit = minones_p0;
      3'd3:    digit = mintens_p0;
      3'd4:    digit = hrsones_p0;
      default: digit = hrstens_p0;
    endcase
    case (mode_p0)
      2'd1:    in_field = (idx == 3'd0) || (idx == 3'd1);
      2'd2:    in_field = (idx == 3'd2) || (idx == 3'd3);
      2'd3:    in_field = (idx == 3'd4) || (idx == 3'd5);
      default: in_field = 1'b0;
    endcase
    // A blinking field only goes dark in the invisible half of the blink period.
    lit = !(in_field && !phase) &&
          !((idx == 3'd5) && blank_lz_p0 && (digit == 4'd0));
    if (lit) begin
      an_nxt  = ~(8'd1 << idx);
      seg_nxt = decode(digit);
      dp_nxt  = !((idx == 3'd2) || (idx == 3'd4));
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against a time-based
// reference model (slot = cycles since release / REFRESH_DIV).
module tb_seg7_scan_driver;

  localparam int RD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 6 * RD;
  localparam logic [6:0] SEGTAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] hrstens = 0, hrsones = 0, mintens = 0, minones = 0, sectens = 0, secones = 0;
  logic [1:0] mode = 0;
  logic       blank_lz = 0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_fail = 0;
  int t = 0;
  logic [3:0] m_snap [6];
  logic [1:0] m_mode;
  logic       m_blz;
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n),
    .hrstens(hrstens), .hrsones(hrsones), .mintens(mintens),
    .minones(minones), .sectens(sectens), .secones(secones),
    .mode(mode), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp(dp));

  always #5 clk = ~clk;

  // Advance one edge and compute what the display must show after it.
  task automatic step();
    int c, slot, i, f;
    logic vis, field, lit;
    logic [3:0] d;
    @(posedge clk);
    if (!rst_n) begin
      t = 0;
      for (int k = 0; k < 6; k++) m_snap[k] = 4'd0;
      m_mode = 2'd0;
      m_blz = 1'b0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      t++;
      c = t - 1; slot = c / RD; i = slot % 6; f = slot / 6;
      vis = ((f / BF) % 2) == 0;
      d = m_snap[i];
      field = (m_mode == 2'd1 && i < 2) || (m_mode == 2'd2 && (i == 2 || i == 3)) ||
              (m_mode == 2'd3 && i >= 4);
      lit = !(field && !vis) && !(i == 5 && m_blz && d == 4'd0);
      exp_an  = lit ? ~(8'd1 << i) : 8'hFF;
      exp_seg = lit ? SEGTAB[d] : 7'h7F;
      exp_dp  = !(lit && (i == 2 || i == 4));
      if (t % FRAME == 0) begin
        m_snap[0] = secones; m_snap[1] = sectens; m_snap[2] = minones;
        m_snap[3] = mintens; m_snap[4] = hrsones; m_snap[5] = hrstens;
        m_mode = mode; m_blz = blank_lz;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    {hrstens, hrsones, mintens, minones, sectens, secones} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    for (int k = 0; k < 3; k++) begin
      step(); n_cmp++;
      if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
        n_fail++; $display("FAIL reset an=%h seg=%h dp=%b want an=ff seg=7f dp=1", an, seg, dp);
      end
    end
    rst_n = 1;
    step(); n_cmp++;
    if ({an, seg} !== {8'hFE, 7'h40}) begin
      n_fail++; $display("FAIL release an=%h seg=%h want an=fe seg=40", an, seg);
    end
    for (int k = 1; k < FRAME; k++) begin
      step(); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++; $display("FAIL frame0 t=%0d an=%h seg=%h dp=%b want %h %h %b", t, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_scan();
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++; $display("FAIL scan t=%0d an=%h seg=%h dp=%b want %h %h %b", t, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_midframe_change();
    for (int k = 0; k < 2 * FRAME + 10; k++) begin
      if (k == 7) secones = 4'd9;
      step(); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++; $display("FAIL midframe t=%0d an=%h seg=%h dp=%b want %h %h %b", t, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_blink();
    mode = 2'd2;
    for (int k = 0; k < 8 * FRAME; k++) begin
      if (k == 6 * FRAME + 5) mode = 2'd0;
      step(); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++; $display("FAIL blink t=%0d an=%h seg=%h dp=%b want %h %h %b", t, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_blank_lz();
    blank_lz = 1; hrstens = 4'd0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      if (k == 2 * FRAME) hrstens = 4'd1;
      step(); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++; $display("FAIL blank_lz t=%0d an=%h seg=%h dp=%b want %h %h %b", t, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    blank_lz = 0;
  endtask

  task automatic test_dash();
    hrsones = 4'd12;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++; $display("FAIL dash t=%0d an=%h seg=%h dp=%b want %h %h %b", t, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) step();
    rst_n = 0;
    step(); n_cmp++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid an=%h seg=%h dp=%b want an=ff seg=7f dp=1", an, seg, dp);
    end
    rst_n = 1;
    step(); n_cmp++;
    if ({an, seg} !== {8'hFE, 7'h40}) begin
      n_fail++; $display("FAIL reset_mid_release an=%h seg=%h want an=fe seg=40", an, seg);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40 * FRAME; k++) begin
      if ($urandom_range(0, 9) == 0)
        {hrstens, hrsones, mintens, minones, sectens, secones} = 24'($urandom);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 39) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 29) == 0) hrstens = 4'd0;
      rst_n = ($urandom_range(0, 299) != 0);
      step(); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++; $display("FAIL random t=%0d an=%h seg=%h dp=%b want %h %h %b", t, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_change();
    test_blink();
    test_blank_lz();
    test_dash();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
